// File: rtl/ahb_burst_ctrl_if.sv
// Signal bundle of the AHB burst sequencer: command port, write/read beat streams
// and the AHB-Lite master bus.
interface ahb_burst_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [2:0]        cmd_burst;

    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              done;
    logic              err;

    logic              hreadyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [1:0]        htrans;
    logic              hreadyin;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst,
        input  wd_valid, wd_data, hreadyout, hresp, hrdata,
        output cmd_ready, wd_ready, rd_valid, rd_data, done, err,
        output haddr, hwdata, hwrite, hsize, hburst, htrans, hreadyin
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst,
        output wd_valid, wd_data, hreadyout, hresp, hrdata,
        input  cmd_ready, wd_ready, rd_valid, rd_data, done, err,
        input  haddr, hwdata, hwrite, hsize, hburst, htrans, hreadyin
    );
endinterface

// File: rtl/ahb_burst_ctrl.sv
// AHB-Lite master burst sequencer: one command at a time, INCR/WRAP address
// generation, BUSY insertion for late write data, wait states and ERROR cancellation.
module ahb_burst_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              hclk,
    input logic              hreset,
    ahb_burst_ctrl_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LAST, S_ERR2} state_t;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_BUSY    = 2'b01;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t            state, state_nxt;
    logic [4:0]        beats_left;
    logic              vld_p1;
    logic [1:0]        htrans_c;
    logic              issue, first_beat, dp_ok, dp_err, is_wrap;
    logic [ADDR_W-1:0] incr, wrap_mask, addr_inc, addr_nxt, cmd_incr;
    logic [2:0]        cmd_hburst;

    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst[2:1])
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            2'b11:   return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    assign is_wrap    = !bus.hburst[0] && (bus.hburst[2:1] != 2'b00);
    assign incr       = ADDR_W'(1) << bus.hsize;
    assign wrap_mask  = (ADDR_W'(burst_beats(bus.hburst)) << bus.hsize) - ADDR_W'(1);
    assign addr_inc   = bus.haddr + incr;
    assign addr_nxt   = is_wrap ? ((bus.haddr & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    assign first_beat = (beats_left == burst_beats(bus.hburst));
    assign issue      = (state == S_ISSUE) && (!bus.hwrite || bus.wd_valid) && bus.hreadyout;
    assign dp_ok      = vld_p1 && bus.hreadyout && (bus.hresp == RESP_OKAY);
    assign dp_err     = vld_p1 && !bus.hreadyout && (bus.hresp == RESP_ERROR);
    assign cmd_incr   = ADDR_W'(1) << bus.cmd_size;
    // Undefined-length INCR runs as a single beat and is reported on the bus as SINGLE.
    assign cmd_hburst = (bus.cmd_burst == 3'b001) ? 3'b000 : bus.cmd_burst;

    always_comb begin
        state_nxt = state;
        htrans_c  = TR_IDLE;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.hwrite && !bus.wd_valid) htrans_c = first_beat ? TR_IDLE : TR_BUSY;
                else                             htrans_c = first_beat ? TR_NONSEQ : TR_SEQ;
                if (dp_err)                             state_nxt = S_ERR2;
                else if (issue && beats_left == 5'd1)   state_nxt = S_LAST;
            end
            S_LAST: begin
                if (dp_err)             state_nxt = S_ERR2;
                else if (bus.hreadyout) state_nxt = S_IDLE;
            end
            S_ERR2: begin
                if (bus.hreadyout) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.wd_ready  = (state == S_ISSUE) && bus.hwrite && bus.hreadyout;
    assign bus.htrans    = htrans_c;
    assign bus.hreadyin  = bus.hreadyout;

    // Address phase (p0) registers and data-phase occupancy (vld_p1).
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state        <= S_IDLE;
            beats_left   <= 5'd0;
            vld_p1       <= 1'b0;
            bus.haddr    <= {ADDR_W{1'b0}};
            bus.hwdata   <= {DATA_W{1'b0}};
            bus.hwrite   <= 1'b0;
            bus.hsize    <= 3'b000;
            bus.hburst   <= 3'b000;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= {DATA_W{1'b0}};
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.rd_valid <= 1'b0;

            if (state == S_IDLE && bus.cmd_valid) begin
                bus.haddr  <= bus.cmd_addr & ~(cmd_incr - ADDR_W'(1));
                bus.hwrite <= bus.cmd_write;
                bus.hsize  <= bus.cmd_size;
                bus.hburst <= cmd_hburst;
                beats_left <= burst_beats(cmd_hburst);
            end

            if (issue) begin
                beats_left <= beats_left - 5'd1;
                bus.haddr  <= addr_nxt;
                if (bus.hwrite) bus.hwdata <= bus.wd_data;
            end

            if (issue)              vld_p1 <= 1'b1;
            else if (bus.hreadyout) vld_p1 <= 1'b0;

            // Data phase (p1) completion feeds the read stream one cycle later.
            if (dp_ok && !bus.hwrite && state != S_ERR2) begin
                bus.rd_valid <= 1'b1;
                bus.rd_data  <= bus.hrdata;
            end

            if ((state == S_LAST || state == S_ERR2) && bus.hreadyout) bus.done <= 1'b1;
            if (bus.hreadyout && (state == S_ERR2 || (state == S_LAST && bus.hresp == RESP_ERROR)))
                bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_burst_ctrl.sv
// Self-checking bench for ahb_burst_ctrl: per-scenario tasks drive the command port and
// a scripted AHB slave, with queue scoreboards for addresses and read data.
module tb_ahb_burst_ctrl;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic hclk = 1'b0;
    logic hreset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ahb_burst_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.hclk(hclk), .hreset(hreset), .bus(bus));

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_size  = 3'd0;
        bus.cmd_burst = 3'd0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = 32'h0;
        bus.hreadyout = 1'b1;
        bus.hresp     = 2'b00;
        bus.hrdata    = 32'h0;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [2:0] burst);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_size  = size;
        bus.cmd_burst = burst;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        n_checks++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %b expected 00", bus.htrans); end
        n_checks++; if (bus.haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h expected 0", bus.haddr); end
        n_checks++; if (bus.hwdata !== 32'h0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: hwdata %h rd_data %h expected 0", bus.hwdata, bus.rd_data); end
        n_checks++; if ({bus.hwrite, bus.rd_valid, bus.done, bus.err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.hwrite, bus.rd_valid, bus.done, bus.err}); end
        n_checks++; if ({bus.hsize, bus.hburst} !== 6'b0) begin n_fail++; $display("FAIL reset_size_burst: got %b expected 000000", {bus.hsize, bus.hburst}); end
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.wd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: cmd_ready %b wd_ready %b expected 1 0", bus.cmd_ready, bus.wd_ready); end
        hreset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int dones = 0;
        idle_inputs();
        bus.wd_valid = 1'b1;
        bus.wd_data  = 32'h80;
        send_cmd(1'b1, 32'h38, 3'd0, 3'b000);
        for (int c = 0; c < 6; c++) begin
            @(negedge hclk);
            if (c == 0) begin
                n_checks++; if (bus.htrans !== TR_NONSEQ || bus.haddr !== 32'h38) begin n_fail++; $display("FAIL single_addr_phase: htrans %b haddr %h expected 10 00000038", bus.htrans, bus.haddr); end
                n_checks++; if (bus.hburst !== 3'b000 || bus.hwrite !== 1'b1 || bus.wd_ready !== 1'b1) begin n_fail++; $display("FAIL single_ctrl: hburst %b hwrite %b wd_ready %b expected 000 1 1", bus.hburst, bus.hwrite, bus.wd_ready); end
            end
            if (c == 1) begin
                n_checks++; if (bus.htrans !== TR_IDLE || bus.hwdata !== 32'h80) begin n_fail++; $display("FAIL single_data_phase: htrans %b hwdata %h expected 00 00000080", bus.htrans, bus.hwdata); end
            end
            if (bus.done === 1'b1) dones++;
            tick();
            if (c == 0) bus.wd_valid = 1'b0;
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_incr8_read();
        logic [31:0] exp_addr[$];
        logic [31:0] exp_rd[$];
        logic [31:0] want;
        int   beats = 0, rds = 0, dones = 0, done_cyc = -1;
        logic dp = 1'b0;
        idle_inputs();
        for (int i = 0; i < 8; i++) exp_addr.push_back(32'h100 + 32'(4 * i));
        send_cmd(1'b0, 32'h100, 3'd2, 3'b101);
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL incr8_cmd_ready_busy: got %b expected 0", bus.cmd_ready); end
        for (int c = 0; c < 14; c++) begin
            bus.hrdata = $urandom;
            if (dp && bus.hreadyout && bus.hresp == 2'b00) exp_rd.push_back(bus.hrdata);
            @(negedge hclk);
            if (bus.htrans[1] === 1'b1 && bus.hreadyout) begin
                n_checks++;
                if (exp_addr.size() == 0) begin n_fail++; $display("FAIL incr8_extra_beat: haddr %h expected no beat", bus.haddr); end
                else begin
                    want = exp_addr.pop_front();
                    if (bus.haddr !== want || bus.htrans !== ((beats == 0) ? TR_NONSEQ : TR_SEQ)) begin
                        n_fail++; $display("FAIL incr8_addr beat %0d: haddr %h htrans %b expected %h %b", beats, bus.haddr, bus.htrans, want, (beats == 0) ? TR_NONSEQ : TR_SEQ);
                    end
                end
                beats++;
            end
            if (bus.rd_valid === 1'b1) begin
                n_checks++;
                if (exp_rd.size() == 0) begin n_fail++; $display("FAIL incr8_rd_extra: rd_data %h expected no beat", bus.rd_data); end
                else begin
                    want = exp_rd.pop_front();
                    if (bus.rd_data !== want) begin n_fail++; $display("FAIL incr8_rd_data beat %0d: got %h expected %h", rds, bus.rd_data, want); end
                end
                rds++;
            end
            if (bus.done === 1'b1) begin
                dones++; done_cyc = c;
                n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL incr8_cmd_ready_at_done: got %b expected 1", bus.cmd_ready); end
            end
            dp = (bus.htrans[1] && bus.hreadyout) ? 1'b1 : (bus.hreadyout ? 1'b0 : dp);
            tick();
        end
        n_checks++; if (beats != 8 || rds != 8) begin n_fail++; $display("FAIL incr8_counts: beats %0d rd %0d expected 8 8", beats, rds); end
        n_checks++; if (dones != 1 || done_cyc != 9) begin n_fail++; $display("FAIL incr8_done: count %0d cycle %0d expected 1 9", dones, done_cyc); end
    endtask

    task automatic test_wrap8_read();
        logic [31:0] wrap_exp [8];
        logic [31:0] exp_addr[$];
        logic [31:0] want;
        int beats = 0, dones = 0;
        idle_inputs();
        wrap_exp = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
        for (int i = 0; i < 8; i++) exp_addr.push_back(wrap_exp[i]);
        send_cmd(1'b0, 32'h38, 3'd2, 3'b100);
        for (int c = 0; c < 14; c++) begin
            bus.hrdata = 32'hC0DE0000 + 32'(c);
            @(negedge hclk);
            if (bus.htrans[1] === 1'b1) begin
                n_checks++;
                if (exp_addr.size() == 0) begin n_fail++; $display("FAIL wrap8_extra_beat: haddr %h expected no beat", bus.haddr); end
                else begin
                    want = exp_addr.pop_front();
                    if (bus.haddr !== want) begin n_fail++; $display("FAIL wrap8_addr beat %0d: got %h expected %h", beats, bus.haddr, want); end
                end
                beats++;
            end
            if (bus.done === 1'b1) dones++;
            tick();
        end
        n_checks++; if (beats != 8 || dones != 1) begin n_fail++; $display("FAIL wrap8_counts: beats %0d done %0d expected 8 1", beats, dones); end
    endtask

    task automatic test_busy_write();
        logic        wv     [9];
        logic [31:0] wdat   [9];
        logic [1:0]  exp_tr [7];
        logic [31:0] exp_ad [6];
        logic [31:0] exp_wd [6];
        int dones = 0, done_cyc = -1;
        idle_inputs();
        wv     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        wdat   = '{32'hD0, 32'hD1, 32'hBAD0, 32'hBAD1, 32'hD2, 32'hD3, 32'h0, 32'h0, 32'h0};
        exp_tr = '{TR_NONSEQ, TR_SEQ, TR_BUSY, TR_BUSY, TR_SEQ, TR_SEQ, TR_IDLE};
        exp_ad = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h10C};
        exp_wd = '{32'hD0, 32'hD1, 32'hD1, 32'hD1, 32'hD2, 32'hD3};
        send_cmd(1'b1, 32'h100, 3'd2, 3'b011);
        for (int c = 0; c < 9; c++) begin
            bus.wd_valid = wv[c];
            bus.wd_data  = wdat[c];
            @(negedge hclk);
            if (c <= 6) begin
                n_checks++; if (bus.htrans !== exp_tr[c]) begin n_fail++; $display("FAIL busy_htrans cycle %0d: got %b expected %b", c, bus.htrans, exp_tr[c]); end
            end
            if (c <= 5) begin
                n_checks++; if (bus.haddr !== exp_ad[c]) begin n_fail++; $display("FAIL busy_haddr cycle %0d: got %h expected %h", c, bus.haddr, exp_ad[c]); end
            end
            if (c >= 1 && c <= 6) begin
                n_checks++; if (bus.hwdata !== exp_wd[c-1]) begin n_fail++; $display("FAIL busy_hwdata cycle %0d: got %h expected %h", c, bus.hwdata, exp_wd[c-1]); end
            end
            if (bus.done === 1'b1) begin dones++; done_cyc = c; end
            tick();
        end
        n_checks++; if (dones != 1 || done_cyc != 7) begin n_fail++; $display("FAIL busy_done: count %0d cycle %0d expected 1 7", dones, done_cyc); end
    endtask

    task automatic test_wait_states();
        int ai  [11];
        int hwb [12];
        logic [31:0] want;
        int dones = 0, done_cyc = -1;
        idle_inputs();
        ai  = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
        hwb = '{0, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
        send_cmd(1'b1, 32'h200, 3'd2, 3'b101);
        for (int c = 0; c < 14; c++) begin
            bus.hreadyout = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            bus.wd_valid  = (c <= 10) ? 1'b1 : 1'b0;
            bus.wd_data   = (c <= 10) ? 32'hA0000000 + 32'(ai[c]) : 32'h0;
            @(negedge hclk);
            if (c <= 11) begin
                n_checks++; if (bus.htrans !== ((c == 0) ? TR_NONSEQ : (c <= 10) ? TR_SEQ : TR_IDLE)) begin n_fail++; $display("FAIL wait_htrans cycle %0d: got %b", c, bus.htrans); end
            end
            if (c <= 10) begin
                want = 32'h200 + 32'(4 * ai[c]);
                n_checks++; if (bus.haddr !== want) begin n_fail++; $display("FAIL wait_haddr cycle %0d: got %h expected %h", c, bus.haddr, want); end
            end
            if (c >= 1 && c <= 11) begin
                want = 32'hA0000000 + 32'(hwb[c]);
                n_checks++; if (bus.hwdata !== want) begin n_fail++; $display("FAIL wait_hwdata cycle %0d: got %h expected %h", c, bus.hwdata, want); end
            end
            if (c == 3) begin
                n_checks++; if (bus.hreadyin !== 1'b0 || bus.wd_ready !== 1'b0) begin n_fail++; $display("FAIL wait_stall_ready: hreadyin %b wd_ready %b expected 0 0", bus.hreadyin, bus.wd_ready); end
            end
            if (bus.done === 1'b1) begin dones++; done_cyc = c; end
            tick();
        end
        n_checks++; if (dones != 1 || done_cyc != 12) begin n_fail++; $display("FAIL wait_done: count %0d cycle %0d expected 1 12", dones, done_cyc); end
    endtask

    task automatic test_error();
        logic [31:0] exp_rd[$];
        logic [31:0] want;
        int   rds = 0, dones = 0, errs = 0, done_cyc = -1, err_cyc = -1;
        logic dp = 1'b0;
        idle_inputs();
        send_cmd(1'b0, 32'h300, 3'd2, 3'b101);
        for (int c = 0; c < 10; c++) begin
            bus.hreadyout = (c == 3) ? 1'b0 : 1'b1;
            bus.hresp     = (c == 3 || c == 4) ? 2'b01 : 2'b00;
            bus.hrdata    = 32'hE0000000 + 32'(c);
            if (dp && bus.hreadyout && bus.hresp == 2'b00) exp_rd.push_back(bus.hrdata);
            @(negedge hclk);
            if (c == 3) begin
                n_checks++; if (bus.htrans !== TR_SEQ || bus.haddr !== 32'h30C) begin n_fail++; $display("FAIL err_first_cycle: htrans %b haddr %h expected 11 0000030c", bus.htrans, bus.haddr); end
            end
            if (c >= 4) begin
                n_checks++; if (bus.htrans !== TR_IDLE) begin n_fail++; $display("FAIL err_htrans_idle cycle %0d: got %b expected 00", c, bus.htrans); end
            end
            if (bus.rd_valid === 1'b1) begin
                n_checks++;
                if (exp_rd.size() == 0) begin n_fail++; $display("FAIL err_rd_extra: rd_data %h expected no beat", bus.rd_data); end
                else begin
                    want = exp_rd.pop_front();
                    if (bus.rd_data !== want) begin n_fail++; $display("FAIL err_rd_data: got %h expected %h", bus.rd_data, want); end
                end
                rds++;
            end
            if (bus.done === 1'b1) begin dones++; done_cyc = c; end
            if (bus.err === 1'b1) begin errs++; err_cyc = c; end
            dp = (bus.htrans[1] && bus.hreadyout) ? 1'b1 : (bus.hreadyout ? 1'b0 : dp);
            tick();
        end
        n_checks++; if (rds != 2) begin n_fail++; $display("FAIL err_rd_count: got %0d expected 2", rds); end
        n_checks++; if (dones != 1 || errs != 1 || done_cyc != 5 || err_cyc != 5) begin n_fail++; $display("FAIL err_pulses: done %0d@%0d err %0d@%0d expected 1@5 1@5", dones, done_cyc, errs, err_cyc); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_cmd_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_undef_incr();
        logic [31:0] exp_rd[$];
        logic [31:0] want;
        int rds = 0, dones = 0;
        idle_inputs();
        send_cmd(1'b0, 32'h103, 3'd2, 3'b001);
        for (int c = 0; c < 5; c++) begin
            bus.hrdata = 32'h7E570000 + 32'(c);
            if (c == 1) exp_rd.push_back(bus.hrdata);
            @(negedge hclk);
            if (c == 0) begin
                n_checks++; if (bus.haddr !== 32'h100 || bus.htrans !== TR_NONSEQ) begin n_fail++; $display("FAIL undef_addr: haddr %h htrans %b expected 00000100 10", bus.haddr, bus.htrans); end
                n_checks++; if (bus.hburst !== 3'b000 || bus.hsize !== 3'd2) begin n_fail++; $display("FAIL undef_ctrl: hburst %b hsize %b expected 000 010", bus.hburst, bus.hsize); end
            end
            if (c == 1) begin
                n_checks++; if (bus.htrans !== TR_IDLE) begin n_fail++; $display("FAIL undef_last_idle: got %b expected 00", bus.htrans); end
            end
            if (bus.rd_valid === 1'b1) begin
                n_checks++;
                if (exp_rd.size() == 0) begin n_fail++; $display("FAIL undef_rd_extra: rd_data %h expected no beat", bus.rd_data); end
                else begin
                    want = exp_rd.pop_front();
                    if (bus.rd_data !== want) begin n_fail++; $display("FAIL undef_rd_data: got %h expected %h", bus.rd_data, want); end
                end
                rds++;
            end
            if (bus.done === 1'b1) dones++;
            tick();
        end
        n_checks++; if (rds != 1 || dones != 1) begin n_fail++; $display("FAIL undef_counts: rd %0d done %0d expected 1 1", rds, dones); end
    endtask

    task automatic test_reset_mid_burst();
        int pulses = 0;
        idle_inputs();
        send_cmd(1'b0, 32'h400, 3'd2, 3'b101);
        for (int c = 0; c < 3; c++) begin
            bus.hrdata = 32'h5A5A0000 + 32'(c);
            tick();
        end
        @(negedge hclk);
        #1 hreset = 1'b1;
        #1;
        n_checks++; if (bus.htrans !== 2'b00 || bus.haddr !== 32'h0) begin n_fail++; $display("FAIL midrst_bus: htrans %b haddr %h expected 00 0", bus.htrans, bus.haddr); end
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_read: rd_valid %b rd_data %h hwrite %b expected 0 0 0", bus.rd_valid, bus.rd_data, bus.hwrite); end
        n_checks++; if ({bus.hsize, bus.hburst} !== 6'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ctrl: size/burst %b cmd_ready %b expected 000000 1", {bus.hsize, bus.hburst}, bus.cmd_ready); end
        if (bus.done === 1'b1 || bus.err === 1'b1) pulses++;
        @(negedge hclk);
        hreset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge hclk);
            if (bus.done === 1'b1 || bus.err === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr8_read();
        test_wrap8_read();
        test_busy_write();
        test_wait_states();
        test_error();
        test_undef_incr();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
